data_mem_ctrl: RTL and testbench

- Memory-side responder for the multicycle core's data/instruction bus; sits directly downstream of the core.
- Accepts level requests (mem_read / mem_write, option = RISC-V funct3, address, write_data).
- Performs byte/half/word access to an internal byte-enabled word SRAM, after a configurable number of wait states.
- Returns formatted, sign/zero-extended load data with a one-cycle mem_response pulse.

---
 rtl/mem_ctrl_pkg.sv | 74 +++++++
 rtl/byte_en_sram.sv | 33 +++
 rtl/data_mem_ctrl.sv | 113 +++++++++++
 tb/tb_data_mem_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// mem_ctrl_pkg - access-type codes, controller state encoding and byte-lane helpers.
// Rev 1.0
package mem_ctrl_pkg;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   // Request attributes captured at acceptance; the address is held separately
   // because its useful width depends on the memory size.
   typedef struct packed {
      logic [31:0] wdata;
      logic [2:0]  opt;
      logic        write;
      logic        err;
   } req_t;

   function automatic logic opt_legal(input logic [2:0] opt);
      case (opt)
         MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

   function automatic logic req_reject(input logic rd, input logic wr,
                                       input logic [2:0] opt, input logic [1:0] a);
      logic misaligned;
      misaligned = ((opt == MEM_H || opt == MEM_HU) && a[0]) ||
                   ((opt == MEM_W) && (a != 2'b00));
      return (rd && wr) || !opt_legal(opt) || misaligned;
   endfunction

   function automatic logic [3:0] lane_mask(input logic [2:0] opt, input logic [1:0] a);
      case (opt)
         MEM_B, MEM_BU: return 4'b0001 << a;
         MEM_H, MEM_HU: return a[1] ? 4'b1100 : 4'b0011;
         default:       return 4'b1111;
      endcase
   endfunction

   // Replicate the right-aligned store data so every lane carries it; the mask picks.
   function automatic logic [31:0] store_lanes(input logic [2:0] opt, input logic [31:0] wdata);
      case (opt)
         MEM_B, MEM_BU: return {4{wdata[7:0]}};
         MEM_H, MEM_HU: return {2{wdata[15:0]}};
         default:       return wdata;
      endcase
   endfunction

   function automatic logic [31:0] load_format(input logic [2:0] opt, input logic [1:0] a,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> {a, 3'b000});
      h = a[1] ? word[31:16] : word[15:0];
      case (opt)
         MEM_B:   return {{24{b[7]}}, b};
         MEM_BU:  return {24'h000000, b};
         MEM_H:   return {{16{h[15]}}, h};
         MEM_HU:  return {16'h0000, h};
         default: return word;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/byte_en_sram.sv
`default_nettype none
// ============================================================================
// Module      : byte_en_sram
// Description : 32-bit word SRAM with per-byte write enables and registered read.
// Revision    : 1.1
// ============================================================================
module byte_en_sram #(
    parameter int    ADDR_WIDTH = 12,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  re,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// data_mem_ctrl - wait-stated byte/half/word memory responder for the multicycle core bus.
// Rev 1.0
module data_mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int    ADDR_WIDTH  = 12,
   parameter int    WAIT_CYCLES = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  option,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        mem_response,
   output logic        mem_err
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   logic [1:0]            state;
   logic [CNT_W-1:0]      wait_cnt;
   req_t                  req;
   logic [ADDR_WIDTH+1:0] req_addr;
   logic [31:0]           held_data;
   logic [31:0]           resp_data;
   logic [31:0]           sram_rdata;
   logic [3:0]            sram_be;
   logic                  sram_re;
   logic                  unused_addr_bits;

   // Upper address bits alias onto the same words.
   assign unused_addr_bits = ^address[31:ADDR_WIDTH+2];

   // Reset in the access cycle must not let the store land.
   assign sram_be = (state == ST_ACCESS && req.write && !req.err && !reset)
                    ? lane_mask(req.opt, req_addr[1:0]) : 4'b0000;
   assign sram_re = (state == ST_ACCESS) && !req.write && !req.err;

   byte_en_sram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_FILE  (INIT_FILE)
   ) u_sram (
      .clock (clock),
      .re    (sram_re),
      .be    (sram_be),
      .addr  (req_addr[ADDR_WIDTH+1:2]),
      .wdata (store_lanes(req.opt, req.wdata)),
      .rdata (sram_rdata)
   );

   always_comb begin
      resp_data = held_data;
      if (req.err) begin
         resp_data = '0;
      end else if (!req.write) begin
         resp_data = load_format(req.opt, req_addr[1:0], sram_rdata);
      end
   end

   // The freshly formatted word is driven during the response cycle and then held.
   assign mem_response = (state == ST_RESP);
   assign mem_err      = (state == ST_RESP) && req.err;
   assign read_data    = (state == ST_RESP) ? resp_data : held_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         held_data <= '0;
         req       <= '0;
         req_addr  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mem_read || mem_write) begin
                  req_addr  <= address[ADDR_WIDTH+1:0];
                  req.wdata <= write_data;
                  req.opt   <= option;
                  req.write <= mem_write;
                  req.err   <= req_reject(mem_read, mem_write, option, address[1:0]);
                  state     <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  wait_cnt <= '0;
                  state    <= ST_ACCESS;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_ACCESS: begin
               state <= ST_RESP;
            end
            ST_RESP: begin
               held_data <= resp_data;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// tb_data_mem_ctrl - directed table, corner sequences and randomized model check of data_mem_ctrl.
// Rev 1.0
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  option;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data, read_data0, read_data4;
   logic        mem_response, mem_response0, mem_response4;
   logic        mem_err, mem_err0, mem_err4;

   always #5 clk = ~clk;

   data_mem_ctrl dut (
      .clock(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .option(option), .address(address), .write_data(write_data),
      .read_data(read_data), .mem_response(mem_response), .mem_err(mem_err)
   );

   data_mem_ctrl #(.WAIT_CYCLES(0)) dut0 (
      .clock(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .option(option), .address(address), .write_data(write_data),
      .read_data(read_data0), .mem_response(mem_response0), .mem_err(mem_err0)
   );

   data_mem_ctrl #(.WAIT_CYCLES(4)) dut4 (
      .clock(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .option(option), .address(address), .write_data(write_data),
      .read_data(read_data4), .mem_response(mem_response4), .mem_err(mem_err4)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  opt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] data;
   } vec_t;

   vec_t        vecs[$];
   int          total = 0;
   int          bad = 0;
   logic [7:0]  mdl [0:16383];
   logic [31:0] last_rd;
   logic [2:0]  legal_opts [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic rd, input logic wr, input logic [2:0] opt, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic err, input logic [31:0] data);
      vec_t v;
      v.rd = rd; v.wr = wr; v.opt = opt; v.addr = addr; v.wdata = wdata; v.err = err; v.data = data;
      vecs.push_back(v);
   endtask

   // Reference: byte-addressed memory of 16 KiB, access size from funct3, aliasing by modulo.
   task automatic model_op(input logic rd, input logic wr, input logic [2:0] opt, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] exp_data, output logic exp_err);
      int     size, base;
      longint val;
      bit     legal, sgn;
      legal = (opt inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      size  = (opt[1:0] == 2'b00) ? 1 : (opt[1:0] == 2'b01) ? 2 : 4;
      sgn   = !opt[2];
      base  = int'(addr % 32'd16384);
      exp_err = (rd && wr) || !legal || (base % size != 0);
      if (exp_err) begin
         exp_data = 32'h0;
         last_rd  = 32'h0;
      end else if (wr) begin
         for (int i = 0; i < size; i++) mdl[base + i] = 8'(wdata >> (8 * i));
         exp_data = last_rd;
      end else begin
         val = 0;
         for (int i = 0; i < size; i++) val += longint'(mdl[base + i]) << (8 * i);
         if (sgn && val >= (64'd1 << (8 * size - 1))) val -= (64'd1 << (8 * size));
         exp_data = 32'(val);
         last_rd  = exp_data;
      end
   endtask

   // Requests are presented for one IDLE cycle, then inputs are scrambled to prove latching.
   task automatic do_op(input logic rd, input logic wr, input logic [2:0] opt, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] got_data, output logic got_err,
                        output int lat);
      mem_read = rd; mem_write = wr; option = opt; address = addr; write_data = wdata;
      lat = 0; got_data = 32'h0; got_err = 1'b0;
      for (int n = 1; n <= 12 && lat == 0; n++) begin
         @(posedge clk); #1;
         if (n == 1) begin
            mem_read = 1'b0; mem_write = 1'b0;
            option = 3'($urandom); address = $urandom; write_data = $urandom;
         end
         if (mem_response) begin
            lat = n; got_data = read_data; got_err = mem_err;
         end
      end
      @(posedge clk); #1;
      check("pulse_width", {31'h0, mem_response}, 32'h0);
   endtask

   task automatic exec(input string tag, input logic rd, input logic wr, input logic [2:0] opt,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit use_tbl,
                       input logic t_err, input logic [31:0] t_data);
      logic [31:0] m_data, g_data, e_data;
      logic        m_err, g_err, e_err;
      int          lat;
      model_op(rd, wr, opt, addr, wdata, m_data, m_err);
      do_op(rd, wr, opt, addr, wdata, g_data, g_err, lat);
      if (use_tbl) begin
         e_err  = t_err;
         e_data = (wr && !rd && !t_err) ? m_data : t_data;
      end else begin
         e_err  = m_err;
         e_data = m_data;
      end
      check({tag, "_lat"}, 32'(lat), 32'd3);
      check({tag, "_err"}, {31'h0, g_err}, {31'h0, e_err});
      check({tag, "_data"}, g_data, e_data);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] m_data, a;
      logic        m_err, rd, wr;
      logic [2:0]  o;
      logic [31:0] mask;
      int          lat_m, lat_0, lat_4, kind;
      bit          seen;

      add(0,1,3'b010,32'h100,32'hDEADBEEF,0,0); add(1,0,3'b010,32'h100,0,0,32'hDEADBEEF);
      add(0,1,3'b010,32'h100,32'h0,0,0);        add(0,1,3'b000,32'h101,32'h0000007F,0,0);
      add(0,1,3'b000,32'h102,32'hAAAAAA80,0,0); add(1,0,3'b000,32'h102,0,0,32'hFFFFFF80);
      add(1,0,3'b100,32'h102,0,0,32'h00000080); add(1,0,3'b010,32'h100,0,0,32'h00807F00);
      add(1,0,3'b000,32'h101,0,0,32'h0000007F); add(1,0,3'b001,32'h100,0,0,32'h00007F00);
      add(1,0,3'b001,32'h102,0,0,32'h00000080); add(0,1,3'b010,32'h204,32'h11223344,0,0);
      add(0,1,3'b001,32'h206,32'hCAFEBEEF,0,0); add(1,0,3'b001,32'h206,0,0,32'hFFFFBEEF);
      add(1,0,3'b101,32'h206,0,0,32'h0000BEEF); add(1,0,3'b010,32'h204,0,0,32'hBEEF3344);
      add(1,0,3'b010,32'h102,0,1,0);            add(0,1,3'b001,32'h103,32'hFFFFFFFF,1,0);
      add(1,0,3'b011,32'h100,0,1,0);            add(0,1,3'b111,32'h100,32'hFFFFFFFF,1,0);
      add(1,1,3'b010,32'h100,32'hFFFFFFFF,1,0); add(1,0,3'b010,32'h100,0,0,32'h00807F00);
      add(1,0,3'b010,32'h40000100,0,0,32'h00807F00);
      add(0,1,3'b010,32'hFFFFC104,32'h55AA55AA,0,0); add(1,0,3'b010,32'h104,0,0,32'h55AA55AA);
      add(0,1,3'b110,32'h104,32'h0,1,0);        add(1,0,3'b101,32'h105,0,1,0);
      add(1,0,3'b000,32'h107,0,0,32'h00000055); add(1,0,3'b000,32'h106,0,0,32'hFFFFFFAA);

      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; option = 3'b0; address = 32'h0; write_data = 32'h0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_resp", {29'h0, mem_response, mem_response0, mem_response4}, 32'h0);
      check("rst_err", {29'h0, mem_err, mem_err0, mem_err4}, 32'h0);
      check("rst_rdata", read_data, 32'h0);
      check("rst_rdata_w0", read_data0, 32'h0);
      check("rst_rdata_w4", read_data4, 32'h0);
      last_rd = 32'h0;

      for (int w = 0; w < 256; w++) exec("init", 1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom, 1'b0, 1'b0, 32'h0);

      for (int i = 0; i < vecs.size(); i++)
         exec($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].opt, vecs[i].addr,
              vecs[i].wdata, 1'b1, vecs[i].err, vecs[i].data);

      // Request held high through the response: a second load starts only from IDLE.
      model_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, m_data, m_err);
      model_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, m_data, m_err);
      mem_read = 1'b1; option = 3'b010; address = 32'h100; mask = 32'h0;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk); #1;
         if (n == 5) mem_read = 1'b0;
         if (mem_response) begin
            mask[n] = 1'b1;
            check("held_rdata", read_data, m_data);
         end
      end
      check("held_mask", mask, 32'h88);

      // Reset landing on the access cycle of a store.
      mem_write = 1'b1; option = 3'b010; address = 32'h300; write_data = 32'h12345678;
      @(posedge clk); #1 mem_write = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("abort_outs", {mem_response, mem_err, 30'h0}, 32'h0);
      check("abort_rdata", read_data, 32'h0);
      last_rd = 32'h0;
      seen = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk); #1;
         if (mem_response) seen = 1'b1;
      end
      check("abort_noresp", {31'h0, seen}, 32'h0);
      exec("abort_mem", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0);

      // Latency for WAIT_CYCLES = 1 (main), 0 and 4 from a common IDLE start.
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      last_rd = 32'h0;
      model_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, m_data, m_err);
      mem_read = 1'b1; option = 3'b010; address = 32'h100;
      lat_m = 0; lat_0 = 0; lat_4 = 0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         if (n == 1) mem_read = 1'b0;
         if (mem_response && lat_m == 0) begin
            lat_m = n;
            check("lat_main_rdata", read_data, m_data);
         end
         if (mem_response0 && lat_0 == 0) begin
            lat_0 = n;
            check("lat_w0_err", {31'h0, mem_err0}, 32'h0);
         end
         if (mem_response4 && lat_4 == 0) begin
            lat_4 = n;
            check("lat_w4_err", {31'h0, mem_err4}, 32'h0);
         end
      end
      check("lat_main", 32'(lat_m), 32'd3);
      check("lat_w0", 32'(lat_0), 32'd2);
      check("lat_w4", 32'(lat_4), 32'd6);

      for (int k = 0; k < 200; k++) begin
         kind = int'($urandom_range(0, 19));
         rd = (kind == 0) || (kind < 10);
         wr = (kind == 0) || (kind >= 10);
         o  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_opts[$urandom_range(0, 4)];
         a  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0) begin
            if (o[1:0] == 2'b01) a[0] = 1'b0;
            else if (o[1:0] == 2'b10) a[1:0] = 2'b00;
         end
         exec($sformatf("rnd%0d", k), rd, wr, o, a, $urandom, 1'b0, 1'b0, 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
